branch_target_buffer_ctrl: RTL and testbench
============================================

Name: branch_target_buffer_ctrl

Overview:
Owns the branch target buffer table: a direct-mapped array of {valid, tag, target, 2-bit counter} entries. Arbitrates the table's single access slot per cycle between fetch-stage lookups and execute-stage update write-backs, buffering updates in a small queue. Applies the standard saturating 2-bit counter update. Runs an init sweep after reset to clear the table.

Parameters:
DEPTH, 16, table entries; power of 2, >=2; IDX_W = log2(DEPTH)
QDEPTH, 4, update queue entries; >=1
STARVE_MAX, 8, max consecutive lookup grants while the queue is non-empty before one update is forced

Ports:
btb_ctrl_clk  in  1  clock
btb_ctrl_rst  in  1  synchronous active-high reset
btb_ctrl_lookup_valid  in  1  fetch requests a lookup this cycle
btb_ctrl_lookup_pc  in  32  fetch PC
btb_ctrl_lookup_ready  out  1  lookup accepted this cycle (combinational grant)
btb_ctrl_hit_valid  out  1  result valid; registered, 1 cycle after an accepted lookup
btb_ctrl_hit  out  1  tag match on a valid entry
btb_ctrl_predict_taken  out  1  counter[1] of the hit entry; 0 on miss
btb_ctrl_predict_target  out  32  target of the hit entry; 0 on miss
btb_ctrl_upd_valid  in  1  execute pushes a resolved branch
btb_ctrl_upd_pc  in  32  branch PC
btb_ctrl_upd_taken  in  1  resolved direction
btb_ctrl_upd_target  in  32  resolved target
btb_ctrl_upd_ready  out  1  queue not full and not in INIT
btb_ctrl_busy_init  out  1  high during the init sweep

Behaviour:
- Clock/reset: one clock, btb_ctrl_clk. Reset is synchronous and active-high on btb_ctrl_rst.
- Index = pc[IDX_W+1:2]; tag = pc[31:IDX_W+2].
- Reset values: state=INIT, init pointer=0, queue empty, starve count=0. hit_valid, hit, predict_taken, predict_target all 0. lookup_ready=0, upd_ready=0, busy_init=1.
- FSM INIT:
  - Each cycle, write entry[ptr] = {valid=0, tag=0, target=0, ctr=2'b01}, then ptr++.
  - After writing entry DEPTH-1, go to RUN. INIT lasts exactly DEPTH cycles.
  - lookup_ready=0 and upd_ready=0 throughout INIT.
- FSM RUN:
  - Only one table operation per cycle: either a lookup grant or one queue drain.
  - Drain is selected if the queue is non-empty AND any of these holds: lookup_valid=0; queue full; starve count == STARVE_MAX.
  - Otherwise a lookup is granted when lookup_valid=1, i.e. lookup_ready = RUN && lookup_valid && !drain_sel.
  - Starve count increments on each lookup grant while the queue is non-empty. It clears on any drain or whenever the queue is empty.
- Lookup: the table is read in the grant cycle; hit/predict outputs are registered for the next cycle.
  - hit_valid is 1 only in the cycle after a grant and 0 otherwise.
  - Lookups see table contents only, with no forwarding from the queue. Stale predictions for queued updates are expected.
- Enqueue: occurs when upd_valid && upd_ready. The queue is FIFO.
  - Simultaneous enqueue and drain is legal: count stays unchanged.
  - upd_ready = RUN && (count < QDEPTH). Enqueue and drain in the same cycle while full is not accepted, because ready is computed from the registered count.
- Drain (read-modify-write in one cycle, applied to the queue head):
  - hit && taken: ctr = min(ctr+1, 3); target = upd_target.
  - hit && !taken: ctr = max(ctr-1, 0); target unchanged.
  - miss && taken: allocate/replace: valid=1, tag=new, target=upd_target, ctr=2'b10.
  - miss && !taken: no change.
- Reset mid-operation: queue flushed, pending result dropped (hit_valid=0 next cycle), INIT restarts at ptr 0.

Optional Feature:
BTB_CTRL_STATS_EN.
- Defined: adds output ports btb_ctrl_stat_lookups[31:0] and btb_ctrl_stat_hits[31:0].
  - stat_lookups increments on every lookup grant; stat_hits increments on every hit_valid && hit.
  - Both counters saturate at 0xFFFF_FFFF and clear on reset.
- Undefined: the ports and logic are absent. All other behaviour is identical.

Test Plan:
1. Reset (DEPTH=16): rst=1 for 2 cycles, then release -> busy_init=1 and lookup_ready=upd_ready=0 for exactly 16 cycles; then ready. Lookup 0x40 -> hit_valid=1, hit=0, predict_taken=0, predict_target=0.
2. Allocation: push {pc=0x40, taken=1, target=0x100} with lookup_valid=0 -> drained next cycle. Then lookup 0x40 -> hit=1, predict_taken=1, predict_target=0x100.
3. Saturation: from test 2, push 2 more taken updates -> ctr=11. Then push 4 not-taken -> ctr steps 10, 01, 00, 00. Lookup 0x40 -> hit=1, predict_taken=0, target still 0x100.
4. Full/starvation (QDEPTH=4, STARVE_MAX=8): hold lookup_valid=1 and push 5 updates back-to-back.
   - 5th update sees upd_ready=0 (queue full).
   - Next cycle is a forced drain with lookup_ready=0.
   - With the queue non-empty but not full, exactly one drain occurs after every 8 lookup grants.
5. Aliasing: after test 2, push taken {pc=0x440, target=0x200} (same index 0) -> entry replaced. Lookup 0x40 -> hit=0; lookup 0x440 -> hit=1, target=0x200, predict_taken=1.
6. Reset mid-op: with 3 updates queued and a lookup granted, assert rst for 1 cycle -> next cycle hit_valid=0, busy_init=1. After 16 cycles, lookup of any previously written PC -> hit=0.

Source files
------------

// File: rtl/branch_target_buffer_ctrl.sv
// -----------------------------------------------------------------------------
// branch_target_buffer_ctrl
//
// Purpose:
//   Owns a direct-mapped branch target buffer of {valid, tag, target, 2-bit
//   counter} entries. The table has a single access slot per cycle, which is
//   shared between fetch lookups and write-backs of resolved branches. Resolved
//   branches wait in a small FIFO until they get the slot. After reset an init
//   sweep clears every entry, one entry per cycle.
//
// Optional feature (compile-time macro BTB_CTRL_STATS_EN):
//   When defined, two saturating 32-bit counters are added as outputs: lookup
//   grants and reported hits.
//
// Ports:
//   btb_ctrl_clk / btb_ctrl_rst   clock, synchronous active-high reset
//   btb_ctrl_lookup_*             fetch lookup request and combinational grant
//   btb_ctrl_hit_valid, _hit,
//   btb_ctrl_predict_*            registered lookup result, one cycle after grant
//   btb_ctrl_upd_*                resolved-branch push into the update FIFO
//   btb_ctrl_busy_init            high while the init sweep is running
//   btb_ctrl_stat_lookups/_hits   (BTB_CTRL_STATS_EN only) event counters
// -----------------------------------------------------------------------------
module branch_target_buffer_ctrl #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned QDEPTH     = 4,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic        btb_ctrl_clk,
  input  logic        btb_ctrl_rst,
  input  logic        btb_ctrl_lookup_valid,
  input  logic [31:0] btb_ctrl_lookup_pc,
  output logic        btb_ctrl_lookup_ready,
  output logic        btb_ctrl_hit_valid,
  output logic        btb_ctrl_hit,
  output logic        btb_ctrl_predict_taken,
  output logic [31:0] btb_ctrl_predict_target,
  input  logic        btb_ctrl_upd_valid,
  input  logic [31:0] btb_ctrl_upd_pc,
  input  logic        btb_ctrl_upd_taken,
  input  logic [31:0] btb_ctrl_upd_target,
  output logic        btb_ctrl_upd_ready,
  output logic        btb_ctrl_busy_init
`ifdef BTB_CTRL_STATS_EN
  ,
  output logic [31:0] btb_ctrl_stat_lookups,
  output logic [31:0] btb_ctrl_stat_hits
`endif
);

  // state  | meaning
  // S_INIT | sweeping the table clear, one entry per cycle; no requests accepted
  // S_RUN  | normal operation; one lookup or one queue drain per cycle

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned TAG_W = 30 - IDX_W;
  localparam int unsigned QP_W  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(QDEPTH + 1);
  localparam int unsigned SV_W  = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e           st_q;
  logic [IDX_W-1:0] init_ptr_q;

  // table storage
  logic             tbl_valid_q  [DEPTH];
  logic [TAG_W-1:0] tbl_tag_q    [DEPTH];
  logic [31:0]      tbl_target_q [DEPTH];
  logic [1:0]       tbl_ctr_q    [DEPTH];

  // update FIFO storage and control
  logic [31:0]      q_pc_q     [QDEPTH];
  logic             q_taken_q  [QDEPTH];
  logic [31:0]      q_target_q [QDEPTH];
  logic [QP_W-1:0]  q_rd_q, q_rd_d;
  logic [QP_W-1:0]  q_wr_q, q_wr_d;
  logic [CNT_W-1:0] q_cnt_q, q_cnt_d;
  logic [SV_W-1:0]  starve_q, starve_d;

  // registered lookup result
  logic             hit_valid_q;
  logic             hit_q;
  logic             pred_taken_q;
  logic [31:0]      pred_target_q;

  logic             in_run;
  logic             q_empty;
  logic             q_full;
  logic             drain_sel;
  logic             lookup_gnt;
  logic             enq;

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic             lk_hit;

  logic [31:0]      hd_pc;
  logic             hd_taken;
  logic [31:0]      hd_target;
  logic [IDX_W-1:0] hd_idx;
  logic [TAG_W-1:0] hd_tag;
  logic             hd_hit;
  logic [1:0]       hd_ctr;
  logic [1:0]       ctr_up;
  logic [1:0]       ctr_dn;

  logic             unused_pc_bits;

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  assign in_run    = (st_q == S_RUN);
  assign q_empty   = (q_cnt_q == '0);
  assign q_full    = (q_cnt_q == CNT_W'(QDEPTH));

  // Drain whenever the slot would otherwise idle, when the FIFO cannot accept
  // more, or when lookups have held the slot for STARVE_MAX grants in a row.
  assign drain_sel  = in_run && !q_empty &&
                      (!btb_ctrl_lookup_valid || q_full ||
                       (starve_q == SV_W'(STARVE_MAX)));
  assign lookup_gnt = in_run && btb_ctrl_lookup_valid && !drain_sel;

  // Ready comes from the registered count, so a full FIFO refuses a push even
  // in a cycle where it is also draining.
  assign btb_ctrl_upd_ready    = in_run && !q_full;
  assign btb_ctrl_lookup_ready = lookup_gnt;
  assign btb_ctrl_busy_init    = (st_q == S_INIT);
  assign enq                   = btb_ctrl_upd_valid && btb_ctrl_upd_ready;

  // ---------------------------------------------------------------------------
  // Lookup read path
  // ---------------------------------------------------------------------------
  assign lk_idx = btb_ctrl_lookup_pc[IDX_W+1:2];
  assign lk_tag = btb_ctrl_lookup_pc[31:IDX_W+2];
  assign lk_hit = tbl_valid_q[lk_idx] && (tbl_tag_q[lk_idx] == lk_tag);

  // ---------------------------------------------------------------------------
  // Drain read-modify-write path (FIFO head)
  // ---------------------------------------------------------------------------
  assign hd_pc     = q_pc_q[q_rd_q];
  assign hd_taken  = q_taken_q[q_rd_q];
  assign hd_target = q_target_q[q_rd_q];
  assign hd_idx    = hd_pc[IDX_W+1:2];
  assign hd_tag    = hd_pc[31:IDX_W+2];
  assign hd_hit    = tbl_valid_q[hd_idx] && (tbl_tag_q[hd_idx] == hd_tag);
  assign hd_ctr    = tbl_ctr_q[hd_idx];
  assign ctr_up    = (hd_ctr == 2'b11) ? 2'b11 : hd_ctr + 2'b01;
  assign ctr_dn    = (hd_ctr == 2'b00) ? 2'b00 : hd_ctr - 2'b01;

  assign unused_pc_bits = ^{btb_ctrl_lookup_pc[1:0], hd_pc[1:0]};

  // ---------------------------------------------------------------------------
  // FIFO pointer / count / starvation next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    q_cnt_d = q_cnt_q;
    if (enq && !drain_sel) begin
      q_cnt_d = q_cnt_q + 1'b1;
    end else if (!enq && drain_sel) begin
      q_cnt_d = q_cnt_q - 1'b1;
    end

    q_wr_d = q_wr_q;
    if (enq) begin
      q_wr_d = (q_wr_q == QP_W'(QDEPTH - 1)) ? '0 : q_wr_q + 1'b1;
    end

    q_rd_d = q_rd_q;
    if (drain_sel) begin
      q_rd_d = (q_rd_q == QP_W'(QDEPTH - 1)) ? '0 : q_rd_q + 1'b1;
    end

    // Only grants made while updates are waiting count toward starvation.
    starve_d = starve_q;
    if (drain_sel || q_empty) begin
      starve_d = '0;
    end else if (lookup_gnt) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge btb_ctrl_clk) begin
    if (btb_ctrl_rst) begin
      st_q          <= S_INIT;
      init_ptr_q    <= '0;
      q_rd_q        <= '0;
      q_wr_q        <= '0;
      q_cnt_q       <= '0;
      starve_q      <= '0;
      hit_valid_q   <= 1'b0;
      hit_q         <= 1'b0;
      pred_taken_q  <= 1'b0;
      pred_target_q <= '0;
`ifdef BTB_CTRL_STATS_EN
      btb_ctrl_stat_lookups <= '0;
      btb_ctrl_stat_hits    <= '0;
`endif
    end else begin
      q_rd_q   <= q_rd_d;
      q_wr_q   <= q_wr_d;
      q_cnt_q  <= q_cnt_d;
      starve_q <= starve_d;

      case (st_q)
        S_INIT: begin
          hit_valid_q <= 1'b0;
          init_ptr_q  <= init_ptr_q + 1'b1;
          if (init_ptr_q == IDX_W'(DEPTH - 1)) begin
            st_q <= S_RUN;
          end
        end
        S_RUN: begin
          hit_valid_q <= lookup_gnt;
          if (lookup_gnt) begin
            hit_q         <= lk_hit;
            pred_taken_q  <= lk_hit && tbl_ctr_q[lk_idx][1];
            pred_target_q <= lk_hit ? tbl_target_q[lk_idx] : 32'h0;
          end
        end
        default: begin
          st_q        <= S_INIT;
          hit_valid_q <= 1'b0;
        end
      endcase

`ifdef BTB_CTRL_STATS_EN
      if (lookup_gnt && (btb_ctrl_stat_lookups != 32'hFFFF_FFFF)) begin
        btb_ctrl_stat_lookups <= btb_ctrl_stat_lookups + 32'd1;
      end
      if (hit_valid_q && hit_q && (btb_ctrl_stat_hits != 32'hFFFF_FFFF)) begin
        btb_ctrl_stat_hits <= btb_ctrl_stat_hits + 32'd1;
      end
`endif
    end
  end

  assign btb_ctrl_hit_valid      = hit_valid_q;
  assign btb_ctrl_hit            = hit_q;
  assign btb_ctrl_predict_taken  = pred_taken_q;
  assign btb_ctrl_predict_target = pred_target_q;

  // ---------------------------------------------------------------------------
  // Table writes: init sweep or drain RMW. No reset needed, the sweep clears it.
  // ---------------------------------------------------------------------------
  always_ff @(posedge btb_ctrl_clk) begin
    if (!btb_ctrl_rst) begin
      if (st_q == S_INIT) begin
        tbl_valid_q[init_ptr_q]  <= 1'b0;
        tbl_tag_q[init_ptr_q]    <= '0;
        tbl_target_q[init_ptr_q] <= '0;
        tbl_ctr_q[init_ptr_q]    <= 2'b01;
      end else if (drain_sel) begin
        if (hd_hit) begin
          if (hd_taken) begin
            tbl_ctr_q[hd_idx]    <= ctr_up;
            tbl_target_q[hd_idx] <= hd_target;
          end else begin
            tbl_ctr_q[hd_idx]    <= ctr_dn;
          end
        end else if (hd_taken) begin
          // allocate or replace the aliasing entry
          tbl_valid_q[hd_idx]  <= 1'b1;
          tbl_tag_q[hd_idx]    <= hd_tag;
          tbl_target_q[hd_idx] <= hd_target;
          tbl_ctr_q[hd_idx]    <= 2'b10;
        end
      end
    end
  end

  // FIFO payload storage; pointers live in the FSM block.
  always_ff @(posedge btb_ctrl_clk) begin
    if (enq) begin
      q_pc_q[q_wr_q]     <= btb_ctrl_upd_pc;
      q_taken_q[q_wr_q]  <= btb_ctrl_upd_taken;
      q_target_q[q_wr_q] <= btb_ctrl_upd_target;
    end
  end

endmodule

// File: tb/tb_branch_target_buffer_ctrl.sv
module tb_branch_target_buffer_ctrl;

  localparam int DEPTH = 16;
  localparam int QD    = 4;
  localparam int SM    = 8;
  localparam int IDXW  = $clog2(DEPTH);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        lv  = 1'b0;
  logic [31:0] lpc = '0;
  logic        uv  = 1'b0;
  logic [31:0] upc = '0;
  logic        utk = 1'b0;
  logic [31:0] utg = '0;

  logic        lready, hv, hit, ptk, uready, busy;
  logic [31:0] ptg;
`ifdef BTB_CTRL_STATS_EN
  logic [31:0] st_lk, st_hit;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  branch_target_buffer_ctrl #(.DEPTH(DEPTH), .QDEPTH(QD), .STARVE_MAX(SM)) dut (
    .btb_ctrl_clk           (clk),
    .btb_ctrl_rst           (rst),
    .btb_ctrl_lookup_valid  (lv),
    .btb_ctrl_lookup_pc     (lpc),
    .btb_ctrl_lookup_ready  (lready),
    .btb_ctrl_hit_valid     (hv),
    .btb_ctrl_hit           (hit),
    .btb_ctrl_predict_taken (ptk),
    .btb_ctrl_predict_target(ptg),
    .btb_ctrl_upd_valid     (uv),
    .btb_ctrl_upd_pc        (upc),
    .btb_ctrl_upd_taken     (utk),
    .btb_ctrl_upd_target    (utg),
    .btb_ctrl_upd_ready     (uready),
    .btb_ctrl_busy_init     (busy)
`ifdef BTB_CTRL_STATS_EN
    ,
    .btb_ctrl_stat_lookups  (st_lk),
    .btb_ctrl_stat_hits     (st_hit)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct {
    logic [31:0] pc;
    bit          taken;
    logic [31:0] tgt;
  } upd_t;

  bit          m_known = 0;
  bit          m_init;
  int          m_ptr;
  bit          m_valid [DEPTH];
  int unsigned m_tag   [DEPTH];
  logic [31:0] m_tgt   [DEPTH];
  int          m_ctr   [DEPTH];
  upd_t        mq[$];
  int          m_starve;
  bit          e_hv, e_hit, e_pt;
  logic [31:0] e_tgt;
`ifdef BTB_CTRL_STATS_EN
  int unsigned m_lookups, m_hits;
`endif

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc >> 2) % DEPTH);
  endfunction
  function automatic int unsigned tag_of(input logic [31:0] pc);
    return int'(pc >> (2 + IDXW));
  endfunction

  always @(negedge clk) begin : cmp
    bit   exp_ur, drain, grant, enq, h;
    int   i;
    upd_t u;
    exp_ur = !m_init && (mq.size() < QD);
    drain  = !m_init && (mq.size() > 0) && (!lv || mq.size() == QD || m_starve == SM);
    grant  = !m_init && lv && !drain;
    if (m_known) begin
      chk("busy_init", busy, m_init);
      chk("upd_ready", uready, exp_ur);
      chk("lookup_ready", lready, grant);
      chk("hit_valid", hv, e_hv);
      if (e_hv) begin
        chk("hit", hit, e_hit);
        chk("predict_taken", ptk, e_pt);
        chk("predict_target", ptg, e_tgt);
      end
`ifdef BTB_CTRL_STATS_EN
      chk("stat_lookups", st_lk, m_lookups);
      chk("stat_hits", st_hit, m_hits);
`endif
    end
    if (rst) begin
      m_known  = 1;
      m_init   = 1;
      m_ptr    = 0;
      mq.delete();
      m_starve = 0;
      e_hv = 0; e_hit = 0; e_pt = 0; e_tgt = '0;
`ifdef BTB_CTRL_STATS_EN
      m_lookups = 0; m_hits = 0;
`endif
    end else if (m_known) begin
`ifdef BTB_CTRL_STATS_EN
      if (e_hv && e_hit) m_hits++;
      if (grant) m_lookups++;
`endif
      if (m_init) begin
        m_valid[m_ptr] = 0; m_tag[m_ptr] = 0; m_tgt[m_ptr] = '0; m_ctr[m_ptr] = 1;
        m_ptr++;
        if (m_ptr == DEPTH) m_init = 0;
        e_hv = 0;
      end else begin
        e_hv = grant;
        if (grant) begin
          i = idx_of(lpc);
          h = m_valid[i] && (m_tag[i] == tag_of(lpc));
          e_hit = h;
          e_pt  = h && (m_ctr[i] >= 2);
          e_tgt = h ? m_tgt[i] : 32'h0;
        end
        if (drain || mq.size() == 0) m_starve = 0;
        else if (grant) m_starve++;
        enq = uv && exp_ur;
        if (drain) begin
          u = mq.pop_front();
          i = idx_of(u.pc);
          h = m_valid[i] && (m_tag[i] == tag_of(u.pc));
          if (h && u.taken) begin
            m_ctr[i] = (m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1;
            m_tgt[i] = u.tgt;
          end else if (h) begin
            m_ctr[i] = (m_ctr[i] - 1 < 0) ? 0 : m_ctr[i] - 1;
          end else if (u.taken) begin
            m_valid[i] = 1; m_tag[i] = tag_of(u.pc); m_tgt[i] = u.tgt; m_ctr[i] = 2;
          end
        end
        if (enq) mq.push_back('{pc: upc, taken: utk, tgt: utg});
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_lookup(input logic [31:0] pc, output logic o_hv, output logic o_hit,
                           output logic o_pt, output logic [31:0] o_tgt);
    int n = 0;
    lv = 1'b1; lpc = pc;
    #1;
    while (!lready && n < 50) begin
      tick(); #1; n++;
    end
    if (n == 50) chk("lookup_grant_timeout", 32'd0, 32'd1);
    tick();
    lv = 1'b0;
    o_hv = hv; o_hit = hit; o_pt = ptk; o_tgt = ptg;
  endtask

  task automatic push(input logic [31:0] pc, input logic tk, input logic [31:0] tg);
    int n = 0;
    uv = 1'b1; upc = pc; utk = tk; utg = tg;
    #1;
    while (!uready && n < 50) begin
      tick(); #1; n++;
    end
    if (n == 50) chk("push_timeout", 32'd0, 32'd1);
    tick();
    uv = 1'b0;
    tick(); // idle slot lets the entry drain
  endtask

  task automatic look_expect(input string name, input logic [31:0] pc, input logic e_h,
                             input logic e_p, input logic [31:0] e_t);
    logic o_hv, o_hit, o_pt;
    logic [31:0] o_tgt;
    do_lookup(pc, o_hv, o_hit, o_pt, o_tgt);
    chk({name, "_hv"}, o_hv, 1'b1);
    chk({name, "_hit"}, o_hit, e_h);
    chk({name, "_pt"}, o_pt, e_p);
    chk({name, "_tgt"}, o_tgt, e_t);
  endtask

  task automatic wait_init(input string name);
    int n = 0;
    #1;
    while (busy && n < 40) begin
      tick(); #1; n++;
    end
    chk(name, n, 16);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    // 1. reset and init sweep
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    wait_init("init_cycles");
    chk("ready_after_init", uready, 1'b1);
    look_expect("cold", 32'h40, 1'b0, 1'b0, 32'h0);

    // 2. allocation
    push(32'h40, 1'b1, 32'h100);
    look_expect("alloc", 32'h40, 1'b1, 1'b1, 32'h100);

    // 3. counter saturation in both directions
    push(32'h40, 1'b1, 32'h100);
    push(32'h40, 1'b1, 32'h100);
    push(32'h40, 1'b0, 32'h0);
    look_expect("sat_hi_nt1", 32'h40, 1'b1, 1'b1, 32'h100);
    push(32'h40, 1'b0, 32'h0);
    look_expect("nt2", 32'h40, 1'b1, 1'b0, 32'h100);
    push(32'h40, 1'b0, 32'h0);
    push(32'h40, 1'b0, 32'h0);
    look_expect("sat_lo", 32'h40, 1'b1, 1'b0, 32'h100);
    push(32'h40, 1'b1, 32'h100);
    look_expect("sat_lo_t1", 32'h40, 1'b1, 1'b0, 32'h100);
    push(32'h40, 1'b1, 32'h100);

    // 5. aliasing on index 0
    push(32'h440, 1'b1, 32'h200);
    look_expect("alias_old", 32'h40, 1'b0, 1'b0, 32'h0);
    look_expect("alias_new", 32'h440, 1'b1, 1'b1, 32'h200);

    // 4. full queue and starvation bound under continuous lookups
    lv = 1'b1; lpc = 32'h1000;
    for (int i = 0; i < 5; i++) begin
      uv = 1'b1; upc = 32'h2000 + 32'(i * 4); utk = 1'b1; utg = 32'h3000 + 32'(i);
      #1;
      if (i == 4) begin
        chk("full_upd_ready", uready, 1'b0);
        chk("forced_drain_lookup_ready", lready, 1'b0);
      end else begin
        chk("fill_upd_ready", uready, 1'b1);
      end
      tick();
    end
    uv = 1'b0;
    for (int k = 0; k < 30; k++) begin
      #1;
      chk("starve_pattern", lready, (k < 27) ? ((k % 9) != 8) : 1'b1);
      tick();
    end
    lv = 1'b0;
    tick();

    // 6. reset mid-operation
    lv = 1'b1; lpc = 32'h440;
    for (int i = 0; i < 3; i++) begin
      uv = 1'b1; upc = 32'h80 + 32'(i * 4); utk = 1'b1; utg = 32'h500;
      tick();
    end
    uv = 1'b0;
    rst = 1'b1;
    #1;
    chk("grant_at_reset", lready, 1'b1);
    tick();
    rst = 1'b0; lv = 1'b0;
    chk("rst_drop_hv", hv, 1'b0);
    chk("rst_busy", busy, 1'b1);
    wait_init("reinit_cycles");
    look_expect("post_rst_440", 32'h440, 1'b0, 1'b0, 32'h0);
    look_expect("post_rst_2000", 32'h2000, 1'b0, 1'b0, 32'h0);

    // randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      lv  = ((c % 400) < 200) ? ($urandom_range(0, 7) != 0) : 1'($urandom_range(0, 1));
      lpc = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2) |
            32'($urandom_range(0, 3));
      uv  = ($urandom_range(0, 2) != 0);
      upc = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2);
      utk = 1'($urandom_range(0, 1));
      utg = $urandom;
      rst = ($urandom_range(0, 599) == 0);
      tick();
    end
    rst = 1'b0; lv = 1'b0; uv = 1'b0;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
